// File: rtl/mutex_arb_pkg.sv
// Shared definitions for mutual-exclusion arbiters: FSM state encoding
// and the width of the grant-hold counter.
package mutex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int HOLD_W = 16;

endpackage

// File: rtl/req_sync.sv
// Single-bit flop-chain synchronizer for an asynchronous request line.
module req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // shift the raw input through the chain; all stages clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rr_mutex_arbiter_chk.sv
// Invariants of the arbiter grant bus: at most one grant bit, busy mirrors it.
module rr_mutex_arbiter_chk #(
    parameter int N = 4
) (
    input logic         clk,
    input logic         reset,
    input logic [N-1:0] grant,
    input logic         busy
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));

    a_busy_matches: assert property (@(posedge clk) disable iff (!reset) busy == (|grant));

endmodule

// File: rtl/rr_mutex_arbiter.sv
// Round-robin mutual-exclusion arbiter for asynchronous 4-phase requesters.
// Requests are synchronized, one owner is granted at a time, and every
// grant is followed by a guaranteed all-zero gap. An optional hold limit
// revokes a grant and masks the owner until it withdraws its request.
module rr_mutex_arbiter
    import mutex_arb_pkg::*;
#(
    parameter int                N           = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [HOLD_W-1:0] MAX_HOLD    = 16'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int             OW       = $clog2(N);
    localparam logic [OW-1:0]  LAST_IDX = OW'(N - 1);
    localparam logic [OW-1:0]  IDX_ONE  = OW'(1'b1);

    logic [N-1:0]        req_s;
    logic [N-1:0]        eligible_s;

    arb_state_e          state_r, state_next_s;
    logic [N-1:0]        grant_r, grant_next_s;
    logic [OW-1:0]       owner_r, owner_next_s;
    logic [OW-1:0]       ptr_r, ptr_next_s;
    logic [N-1:0]        mask_r, mask_next_s;
    logic [HOLD_W-1:0]   hold_r, hold_next_s;
    logic                busy_r;
    logic                timeout_r, timeout_next_s;

    logic                found_hi_s, found_lo_s, found_s;
    logic [OW-1:0]       win_hi_s, win_lo_s, winner_s;
    logic [OW-1:0]       next_idx_s;
    logic                hold_expired_s;

    for (genvar gi = 0; gi < N; gi++) begin : g_sync
        req_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_req_sync (
            .clk   (clk),
            .rst_n (reset),
            .d     (req[gi]),
            .q     (req_s[gi])
        );
    end

    assign eligible_s     = req_s & ~mask_r;
    assign next_idx_s     = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_ONE;
    assign hold_expired_s = (MAX_HOLD != 16'd0) && (hold_r == (MAX_HOLD - 16'd1));

    // round-robin pick: lowest eligible index at or above ptr, else lowest overall
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        win_hi_s   = '0;
        win_lo_s   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            found_lo_s = found_lo_s | eligible_s[j];
            win_lo_s   = eligible_s[j] ? OW'(j) : win_lo_s;
            found_hi_s = found_hi_s | (eligible_s[j] && (j >= int'(ptr_r)));
            win_hi_s   = (eligible_s[j] && (j >= int'(ptr_r))) ? OW'(j) : win_hi_s;
        end
        found_s  = found_lo_s;
        winner_s = found_hi_s ? win_hi_s : win_lo_s;
    end

    // next-state and next-output logic of the IDLE/GRANT/GAP handshake FSM
    always_comb begin
        state_next_s   = state_r;
        grant_next_s   = grant_r;
        owner_next_s   = owner_r;
        ptr_next_s     = ptr_r;
        hold_next_s    = hold_r;
        timeout_next_s = 1'b0;
        mask_next_s    = mask_r & req_s;
        case (state_r)
            IDLE: begin
                hold_next_s = 16'd0;
                if (found_s) begin
                    grant_next_s           = '0;
                    grant_next_s[winner_s] = 1'b1;
                    owner_next_s           = winner_s;
                    state_next_s           = GRANT;
                end else begin
                    grant_next_s = '0;
                    owner_next_s = '0;
                end
            end
            GRANT: begin
                if (!req_s[owner_r]) begin
                    grant_next_s = '0;
                    owner_next_s = '0;
                    ptr_next_s   = next_idx_s;
                    state_next_s = GAP;
                end else if (hold_expired_s) begin
                    // revoke: owner stays masked until it lets go of req
                    grant_next_s         = '0;
                    owner_next_s         = '0;
                    ptr_next_s           = next_idx_s;
                    timeout_next_s       = 1'b1;
                    mask_next_s[owner_r] = 1'b1;
                    state_next_s         = GAP;
                end else begin
                    hold_next_s = hold_r + 16'd1;
                end
            end
            GAP: begin
                grant_next_s = '0;
                owner_next_s = '0;
                state_next_s = IDLE;
            end
            default: begin
                grant_next_s = '0;
                owner_next_s = '0;
                state_next_s = IDLE;
            end
        endcase
    end

    // state and registered outputs; async reset clears everything at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            owner_r   <= '0;
            ptr_r     <= '0;
            mask_r    <= '0;
            hold_r    <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            grant_r   <= grant_next_s;
            owner_r   <= owner_next_s;
            ptr_r     <= ptr_next_s;
            mask_r    <= mask_next_s;
            hold_r    <= hold_next_s;
            busy_r    <= |grant_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    assign grant       = grant_r;
    assign owner       = owner_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
// Directed self-checking bench for rr_mutex_arbiter: one instance without a
// hold limit (dut0) and one with MAX_HOLD=8 (dut8), sharing clock and reset.
module tb_rr_mutex_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req0, req8;
    logic [3:0] grant0, grant8;
    logic [1:0] owner0, owner8;
    logic       busy0, busy8;
    logic       timeout0, timeout8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mutex_arbiter #(.N(4), .SYNC_STAGES(2), .MAX_HOLD(16'd0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .grant(grant0),
        .owner(owner0), .busy(busy0), .timeout_err(timeout0)
    );

    rr_mutex_arbiter #(.N(4), .SYNC_STAGES(2), .MAX_HOLD(16'd8)) dut8 (
        .clk(clk), .reset(reset), .req(req8), .grant(grant8),
        .owner(owner8), .busy(busy8), .timeout_err(timeout8)
    );

    rr_mutex_arbiter_chk #(.N(4)) chk0 (.clk(clk), .reset(reset), .grant(grant0), .busy(busy0));
    rr_mutex_arbiter_chk #(.N(4)) chk8 (.clk(clk), .reset(reset), .grant(grant8), .busy(busy8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0  = 4'b0000;
        req8  = 4'b0000;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0  = 4'b0000;
        req8  = 4'b0000;
        ticks(2);
        checks++; if (grant0 !== 4'b0000) begin failures++; $display("FAIL reset_grant0: got %b expected 0000", grant0); end
        checks++; if (owner0 !== 2'd0) begin failures++; $display("FAIL reset_owner0: got %0d expected 0", owner0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (timeout0 !== 1'b0) begin failures++; $display("FAIL reset_timeout0: got %b expected 0", timeout0); end
        checks++; if (grant8 !== 4'b0000) begin failures++; $display("FAIL reset_grant8: got %b expected 0000", grant8); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int bad;
        req0 = 4'b0010;
        ticks(2);
        checks++; if (grant0 !== 4'b0000) begin failures++; $display("FAIL single_early: got %b expected 0000", grant0); end
        tick();
        checks++; if (grant0 !== 4'b0010) begin failures++; $display("FAIL single_grant: got %b expected 0010", grant0); end
        checks++; if (owner0 !== 2'd1) begin failures++; $display("FAIL single_owner: got %0d expected 1", owner0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy0); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant0 !== 4'b0010 || timeout0 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_hold_nolimit: got %0d bad cycles expected 0", bad); end
        req0 = 4'b0000;
        ticks(2);
        checks++; if (grant0 !== 4'b0010) begin failures++; $display("FAIL single_release_early: got %b expected 0010", grant0); end
        tick();
        checks++; if (grant0 !== 4'b0000) begin failures++; $display("FAIL single_release: got %b expected 0000", grant0); end
        checks++; if (owner0 !== 2'd0) begin failures++; $display("FAIL single_release_owner: got %0d expected 0", owner0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL single_release_busy: got %b expected 0", busy0); end
        ticks(2);
    endtask

    task automatic test_round_robin();
        int         zeros;
        int         w;
        logic [1:0] idx;
        logic [3:0] exp_v;
        do_reset();
        req0 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx   = 2'(k % 4);
            exp_v = 4'b0001 << idx;
            zeros = 0;
            w     = 0;
            while (grant0 === 4'b0000 && w < 20) begin
                zeros++;
                tick();
                w++;
            end
            checks++; if (grant0 !== exp_v) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", k, grant0, exp_v); end
            checks++; if (owner0 !== idx) begin failures++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", k, owner0, idx); end
            if (k > 0) begin
                checks++; if (zeros < 2) begin failures++; $display("FAIL rr_gap[%0d]: got %0d zero cycles expected >=2", k, zeros); end
            end
            ticks(3);
            req0[idx] = 1'b0;
            tick();
            req0[idx] = 1'b1;
            w = 0;
            while (grant0 !== 4'b0000 && w < 20) begin
                tick();
                w++;
            end
        end
        req0 = 4'b0000;
        ticks(6);
    endtask

    task automatic test_timeout();
        int bad;
        req8 = 4'b0100;
        ticks(3);
        checks++; if (grant8 !== 4'b0100) begin failures++; $display("FAIL to_grant: got %b expected 0100", grant8); end
        req8[0] = 1'b1;
        bad = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (grant8 !== 4'b0100 || timeout8 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL to_hold: got %0d bad cycles expected 0", bad); end
        tick();
        checks++; if (grant8 !== 4'b0000) begin failures++; $display("FAIL to_revoke: got %b expected 0000", grant8); end
        checks++; if (timeout8 !== 1'b1) begin failures++; $display("FAIL to_err_pulse: got %b expected 1", timeout8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL to_busy: got %b expected 0", busy8); end
        tick();
        checks++; if (timeout8 !== 1'b0) begin failures++; $display("FAIL to_err_width: got %b expected 0", timeout8); end
        tick();
        checks++; if (grant8 !== 4'b0001) begin failures++; $display("FAIL to_other_grant: got %b expected 0001", grant8); end
        checks++; if (owner8 !== 2'd0) begin failures++; $display("FAIL to_other_owner: got %0d expected 0", owner8); end
        req8[0] = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant8[2] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL to_no_regrant: got %0d cycles with grant[2] expected 0", bad); end
        checks++; if (grant8 !== 4'b0000) begin failures++; $display("FAIL to_idle: got %b expected 0000", grant8); end
        req8[2] = 1'b0;
        tick();
        req8[2] = 1'b1;
        ticks(3);
        checks++; if (grant8 !== 4'b0100) begin failures++; $display("FAIL to_regrant: got %b expected 0100", grant8); end
        req8 = 4'b0000;
        ticks(5);
    endtask

    task automatic test_reset_mid_grant();
        req0 = 4'b0100;
        ticks(3);
        req0 = 4'b0000;
        ticks(3);
        req0 = 4'b0100;
        ticks(3);
        checks++; if (grant0 !== 4'b0100) begin failures++; $display("FAIL rst_pre_grant: got %b expected 0100", grant0); end
        req0 = 4'b1100;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (grant0 !== 4'b0000) begin failures++; $display("FAIL rst_async_grant: got %b expected 0000", grant0); end
        checks++; if (owner0 !== 2'd0) begin failures++; $display("FAIL rst_async_owner: got %0d expected 0", owner0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b expected 0", busy0); end
        tick();
        reset = 1'b1;
        ticks(2);
        checks++; if (grant0 !== 4'b0000) begin failures++; $display("FAIL rst_release_early: got %b expected 0000", grant0); end
        tick();
        checks++; if (grant0 !== 4'b0100) begin failures++; $display("FAIL rst_ptr_zero: got %b expected 0100", grant0); end
        req0 = 4'b0000;
        ticks(6);
    endtask

    task automatic test_withdrawn();
        int bad;
        req0 = 4'b0001;
        ticks(3);
        checks++; if (grant0 !== 4'b0001) begin failures++; $display("FAIL wd_owner_grant: got %b expected 0001", grant0); end
        req0 = 4'b1001;
        ticks(3);
        req0 = 4'b0001;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant0 !== 4'b0001) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL wd_hold: got %0d bad cycles expected 0", bad); end
        req0 = 4'b0000;
        ticks(3);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (grant0 !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL wd_no_pulse: got %0d nonzero cycles expected 0", bad); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_grant();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mutex_arbiter.md
RR_MUTEX_ARBITER -- requirements
Module: rr_mutex_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per request bit (min 2).
REQ-003 The block SHALL have parameter MAX_HOLD, default 0, giving the grant-hold cycle limit (0 = no limit; width 16).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N bits: asynchronous 4-phase requests, one per requester.
REQ-007 The block SHALL have port grant, output, N bits: registered one-hot-or-zero grants.
REQ-008 The block SHALL have port owner, output, clog2(N) bits: index of the current grantee, 0 when none.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any grant bit is high.
REQ-010 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-011 Each req bit SHALL pass through a SYNC_STAGES flop chain (reset 0); all decisions use only synchronized req_s.
REQ-012 The FSM SHALL have states IDLE, GRANT and GAP.
- IDLE: if any eligible req_s bit is set, select the winner, set grant[winner], and go to GRANT at the next edge.
- GRANT: hold grant while req_s[owner]=1; when req_s[owner]=0, clear grant at the next edge and go to GAP.
- GAP: one cycle with grant all-zero, then go to IDLE.
REQ-013 Winner SHALL be the first eligible index searching ptr, ptr+1, ..., N-1, 0, ... (mod N); ptr resets to 0.
REQ-014 On leaving GRANT, ptr SHALL become (owner+1) mod N.
REQ-015 grant SHALL never have more than one bit set; it SHALL be driven directly from flops (glitch-free).
REQ-016 Between two consecutive grants, grant SHALL be all-zero for at least 2 cycles (GAP plus IDLE).
REQ-017 Latency, SYNC_STAGES=2: a req rise set up before edge e SHALL give req_s high after e+1 and grant high after e+2 (IDLE, eligible, winning).
REQ-018 Latency, SYNC_STAGES=2: a req fall set up before edge f SHALL give grant low after edge f+2.
REQ-019 MAX_HOLD behaviour, when MAX_HOLD>0:
- A hold counter SHALL clear on entering GRANT and increment each GRANT cycle.
- When it reaches MAX_HOLD, grant SHALL clear at the next edge, with timeout_err high for exactly that cycle and state GAP.
- The owner's mask bit SHALL be set.
REQ-020 A masked requester SHALL be ineligible; its mask bit SHALL clear when its req_s is 0.
REQ-021 A req_s that drops in IDLE before being granted SHALL be dropped from arbitration without any grant pulse.
REQ-022 If all N req_s rise in the same cycle, grants SHALL be issued in ptr order, one full handshake each.
REQ-023 owner SHALL update with grant; busy SHALL equal OR of grant, registered.

Reset
REQ-024 Asserting reset (low) at any time, including mid-grant, SHALL immediately clear grant, owner, busy, timeout_err, ptr, mask, the hold counter and all synchronizer flops, and set state IDLE.
REQ-025 Deassertion SHALL be synchronous to clk at the integration level; no request is granted earlier than SYNC_STAGES+1 edges after release.

Structure
REQ-026 The state encodings (IDLE=2'b00, GRANT=2'b01, GAP=2'b10) and the hold-counter width SHALL live in a shared mutex_arb_pkg include, reused by future arbiters.
REQ-027 The synchronizer SHALL be a separate sub-module req_sync (1-bit, SYNC_STAGES parameter, async active-low reset), instantiated N times.

Verification
REQ-028 Single request: with N=4, req=4'b0010 held → grant=4'b0010 two edges after sampling, owner=1, busy=1; req=0 → grant=0 two edges later.
REQ-029 Round robin: req=4'b1111 held, each owner drops and reasserts req 3 cycles after its grant → grant order 0,1,2,3,0 with ≥2 zero cycles between grants.
REQ-030 Timeout: MAX_HOLD=8, req[2] held forever → grant[2] high for 8 cycles, then cleared with a 1-cycle timeout_err; req[2] SHALL not be re-granted until it drops and reasserts, and req[0] is granted meanwhile.
REQ-031 Reset mid-grant: grant=4'b0100, then reset low asynchronously between edges → grant, owner and busy go to 0 immediately; after release ptr=0, so req=4'b1100 → grant=4'b0100.
REQ-032 Withdrawn request: req[3] pulses high for 3 cycles while another requester owns → no grant[3] pulse, and the assertion that grant has no more than one bit set holds throughout.
